// File: rtl/term_switch_matrix_cfg_pkg.sv
// Shared route-mode encoding and configuration sizing for the terminal switch matrix.
package term_sm_pkg;

  typedef enum logic [1:0] {
    MODE_REV  = 2'b00,
    MODE_STR  = 2'b01,
    MODE_ZERO = 2'b10,
    MODE_HOLD = 2'b11
  } route_mode_e;

  // Two mode bits per southbound output across all four wire groups.
  function automatic int calc_cfg_w(input int n1_w, input int n2_w, input int n4_w);
    return 2 * (n1_w + 2 * n2_w + n4_w);
  endfunction

endpackage

// File: rtl/term_switch_matrix_cfg_if.sv
// Serial configuration port: shift/commit strobes in, load status out.
interface term_switch_matrix_cfg_if;
  logic cfg_en;
  logic cfg_bit;
  logic cfg_commit;
  logic cfg_full;
  logic cfg_err;

  modport master (
    output cfg_en, cfg_bit, cfg_commit,
    input  cfg_full, cfg_err
  );

  modport slave (
    input  cfg_en, cfg_bit, cfg_commit,
    output cfg_full, cfg_err
  );
endinterface

// File: rtl/term_switch_matrix_cfg_route_lane.sv
// One wire group: per-output mode mux, hold registers and optional output register.
module term_route_lane
  import term_sm_pkg::*;
#(
  parameter int W    = 4,
  parameter int PIPE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*W-1:0] mode_i,
  input  logic [W-1:0]   in_i,
  output logic [W-1:0]   out_o
);

  logic [W-1:0] rev;
  logic [W-1:0] sel;
  logic [W-1:0] hold_q;
  logic [W-1:0] hold_d;

  // Index-reversed copy of the input group (legacy fold).
  always_comb begin
    rev = '0;
    for (int i = 0; i < W; i++) begin
      rev[i] = in_i[W-1-i];
    end
  end

  // Mode mux; hold registers track the fold until their output enters hold mode.
  always_comb begin
    sel    = '0;
    hold_d = hold_q;
    for (int i = 0; i < W; i++) begin
      case (mode_i[2*i +: 2])
        MODE_REV:  sel[i] = rev[i];
        MODE_STR:  sel[i] = in_i[i];
        MODE_ZERO: sel[i] = 1'b0;
        MODE_HOLD: sel[i] = hold_q[i];
        default:   sel[i] = rev[i];
      endcase
      hold_d[i] = (mode_i[2*i +: 2] == MODE_HOLD) ? hold_q[i] : rev[i];
    end
  end

  // Hold register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  if (PIPE != 0) begin : g_pipe
    logic [W-1:0] out_q;
    // Optional output stage for timing closure at the tile edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) out_q <= '0;
      else     out_q <= sel;
    end
    assign out_o = out_q;
  end else begin : g_comb
    assign out_o = sel;
  end

endmodule

// File: rtl/term_switch_matrix_cfg.sv
// Runtime-configurable north-edge termination fold with serial shadow config.
module term_switch_matrix_cfg
  import term_sm_pkg::*;
#(
  parameter int N1_W = 4,
  parameter int N2_W = 8,
  parameter int N4_W = 16,
  parameter int PIPE = 0
) (
  input  logic                     UserCLK,
  input  logic                     RST,
  term_switch_matrix_cfg_if.slave  cfg,
  input  logic [N1_W-1:0]          N1END,
  input  logic [N2_W-1:0]          N2MID,
  input  logic [N2_W-1:0]          N2END,
  input  logic [N4_W-1:0]          N4END,
  output logic [N1_W-1:0]          S1BEG,
  output logic [N2_W-1:0]          S2BEG,
  output logic [N2_W-1:0]          S2BEGb,
  output logic [N4_W-1:0]          S4BEG
);

  localparam int CFG_W  = calc_cfg_w(N1_W, N2_W, N4_W);
  localparam int CNT_W  = $clog2(CFG_W + 2);
  localparam int OFF_S2 = N1_W;
  localparam int OFF_SB = N1_W + N2_W;
  localparam int OFF_S4 = N1_W + 2 * N2_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(CFG_W + 1);

  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             err_q, err_d;

  // Commit evaluates the pre-shift count and shadow; a same-cycle shift restarts the count at 1.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    if (cfg.cfg_commit) begin
      if (cnt_q == FULL_CNT) active_d = shadow_q;
      else                   err_d    = 1'b1;
      cnt_d = '0;
    end
    if (cfg.cfg_en) begin
      shadow_d = {cfg.cfg_bit, shadow_q[CFG_W-1:1]};
      if (cfg.cfg_commit)       cnt_d = CNT_W'(1);
      else if (cnt_q != SAT_CNT) cnt_d = cnt_q + CNT_W'(1);
    end
    full_d = (cnt_d == FULL_CNT);
  end

  // Configuration state registers.
  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      err_q    <= err_d;
    end
  end

  assign cfg.cfg_full = full_q;
  assign cfg.cfg_err  = err_q;

  term_route_lane #(.W(N1_W), .PIPE(PIPE)) u_lane_s1 (
    .clk    (UserCLK),
    .rst    (RST),
    .mode_i (active_q[0 +: 2*N1_W]),
    .in_i   (N1END),
    .out_o  (S1BEG)
  );

  term_route_lane #(.W(N2_W), .PIPE(PIPE)) u_lane_s2 (
    .clk    (UserCLK),
    .rst    (RST),
    .mode_i (active_q[2*OFF_S2 +: 2*N2_W]),
    .in_i   (N2MID),
    .out_o  (S2BEG)
  );

  term_route_lane #(.W(N2_W), .PIPE(PIPE)) u_lane_s2b (
    .clk    (UserCLK),
    .rst    (RST),
    .mode_i (active_q[2*OFF_SB +: 2*N2_W]),
    .in_i   (N2END),
    .out_o  (S2BEGb)
  );

  term_route_lane #(.W(N4_W), .PIPE(PIPE)) u_lane_s4 (
    .clk    (UserCLK),
    .rst    (RST),
    .mode_i (active_q[2*OFF_S4 +: 2*N4_W]),
    .in_i   (N4END),
    .out_o  (S4BEG)
  );

endmodule

// File: tb/tb_term_switch_matrix_cfg.sv
// Bench for term_switch_matrix_cfg: PIPE=0 and PIPE=1 instances share stimulus.
module tb_term_switch_matrix_cfg;

  localparam int CFG_W = 72;
  localparam int NOUT  = 36;

  logic clk = 1'b0;
  logic rst;
  logic en_v, bit_v, com_v;
  logic [3:0]  n1;
  logic [7:0]  n2m, n2e;
  logic [15:0] n4;

  logic [3:0]  s1_0, s1_1;
  logic [7:0]  s2_0, s2_1, s2b_0, s2b_1;
  logic [15:0] s4_0, s4_1;

  int n_chk = 0;
  int n_err = 0;

  logic [CFG_W-1:0] m_act, m_sh;
  logic [NOUT-1:0]  m_hold;
  int               m_cnt;
  logic             m_full, m_err;
  logic [NOUT-1:0]  q1[$];

  always #5 clk = ~clk;

  term_switch_matrix_cfg_if cif0 ();
  term_switch_matrix_cfg_if cif1 ();

  assign cif0.cfg_en = en_v;  assign cif0.cfg_bit = bit_v;  assign cif0.cfg_commit = com_v;
  assign cif1.cfg_en = en_v;  assign cif1.cfg_bit = bit_v;  assign cif1.cfg_commit = com_v;

  term_switch_matrix_cfg #(.N1_W(4), .N2_W(8), .N4_W(16), .PIPE(0)) u_dut0 (
    .UserCLK (clk), .RST (rst), .cfg (cif0),
    .N1END (n1), .N2MID (n2m), .N2END (n2e), .N4END (n4),
    .S1BEG (s1_0), .S2BEG (s2_0), .S2BEGb (s2b_0), .S4BEG (s4_0)
  );

  term_switch_matrix_cfg #(.N1_W(4), .N2_W(8), .N4_W(16), .PIPE(1)) u_dut1 (
    .UserCLK (clk), .RST (rst), .cfg (cif1),
    .N1END (n1), .N2MID (n2m), .N2END (n2e), .N4END (n4),
    .S1BEG (s1_1), .S2BEG (s2_1), .S2BEGb (s2b_1), .S4BEG (s4_1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [NOUT-1:0] fold_vec(input logic [3:0] a, input logic [7:0] b,
                                               input logic [7:0] c, input logic [15:0] d);
    logic [NOUT-1:0] r;
    for (int i = 0; i < 4; i++)  r[i]      = a[3-i];
    for (int i = 0; i < 8; i++)  r[4+i]    = b[7-i];
    for (int i = 0; i < 8; i++)  r[12+i]   = c[7-i];
    for (int i = 0; i < 16; i++) r[20+i]   = d[15-i];
    return r;
  endfunction

  function automatic logic [NOUT-1:0] exp_out(input logic [CFG_W-1:0] act, input logic [NOUT-1:0] hold,
                                              input logic [NOUT-1:0] r, input logic [NOUT-1:0] s);
    logic [NOUT-1:0] o;
    for (int k = 0; k < NOUT; k++) begin
      case (act[2*k +: 2])
        2'b00:   o[k] = r[k];
        2'b01:   o[k] = s[k];
        2'b10:   o[k] = 1'b0;
        default: o[k] = hold[k];
      endcase
    end
    return o;
  endfunction

  function automatic logic [CFG_W-1:0] mk_cfg(input logic [1:0] m1, input logic [1:0] m2,
                                              input logic [1:0] m2b, input logic [1:0] m4);
    logic [CFG_W-1:0] c;
    for (int k = 0; k < NOUT; k++) begin
      if (k < 4)       c[2*k +: 2] = m1;
      else if (k < 12) c[2*k +: 2] = m2;
      else if (k < 20) c[2*k +: 2] = m2b;
      else             c[2*k +: 2] = m4;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_act = '0; m_sh = '0; m_hold = '0; m_cnt = 0; m_full = 1'b0; m_err = 1'b0;
    q1.delete();
    q1.push_back('0);
  endtask

  // One clock cycle: drive strobes, score both instances at negedge, advance the model at posedge.
  task automatic step(input logic en, input logic b, input logic cm);
    logic [NOUT-1:0] r, s, e0, e1;
    en_v = en; bit_v = b; com_v = cm;
    @(negedge clk);
    r  = fold_vec(n1, n2m, n2e, n4);
    s  = {n4, n2e, n2m, n1};
    e0 = exp_out(m_act, m_hold, r, s);
    chk("out_p0", {s4_0, s2b_0, s2_0, s1_0}, e0);
    if (q1.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL sb_empty got=0 exp=1");
    end else begin
      e1 = q1.pop_front();
      chk("out_p1", {s4_1, s2b_1, s2_1, s1_1}, e1);
    end
    q1.push_back(e0);
    chk("cfg_stat", {cif0.cfg_full, cif0.cfg_err, cif1.cfg_full, cif1.cfg_err},
        {m_full, m_err, m_full, m_err});
    @(posedge clk);
    for (int k = 0; k < NOUT; k++)
      if (m_act[2*k +: 2] != 2'b11) m_hold[k] = r[k];
    m_err = 1'b0;
    if (cm) begin
      if (m_cnt == CFG_W) m_act = m_sh;
      else                m_err = 1'b1;
      m_cnt = 0;
    end
    if (en) begin
      m_sh = {b, m_sh[CFG_W-1:1]};
      if (cm)                    m_cnt = 1;
      else if (m_cnt < CFG_W + 1) m_cnt = m_cnt + 1;
    end
    m_full = (m_cnt == CFG_W);
    #1;
    en_v = 1'b0; bit_v = 1'b0; com_v = 1'b0;
  endtask

  task automatic shift_cfg(input logic [CFG_W-1:0] c, input int n);
    for (int j = 0; j < n; j++) step(1'b1, c[j % CFG_W], 1'b0);
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_p0_fold", {s4_0, s2b_0, s2_0, s1_0}, fold_vec(n1, n2m, n2e, n4));
    chk("rst_p1_zero", {s4_1, s2b_1, s2_1, s1_1}, 36'h0);
    chk("rst_stat", {cif0.cfg_full, cif0.cfg_err, cif1.cfg_full, cif1.cfg_err}, 4'b0000);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en_v = 1'b0; bit_v = 1'b0; com_v = 1'b0;
    n1 = 4'b0011; n2m = 8'hA5; n2e = 8'h3C; n4 = 16'h0001;
    #2;
    chk("rst_s4_fold", s4_0, 16'h8000);
    chk("rst_s1_fold", s1_0, 4'b1100);
    chk("rst_p1_zero", {s4_1, s2b_1, s2_1, s1_1}, 36'h0);
    chk("rst_stat", {cif0.cfg_full, cif0.cfg_err, cif1.cfg_full, cif1.cfg_err}, 4'b0000);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Short load is rejected; fold stays, error pulses one cycle.
    shift_cfg(mk_cfg(2'b01, 2'b01, 2'b01, 2'b01), CFG_W - 1);
    chk("short_not_full", cif0.cfg_full, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("short_err", {cif0.cfg_err, cif1.cfg_err}, 2'b11);
    chk("short_keep_fold", s1_0, 4'b1100);
    step(1'b0, 1'b0, 1'b0);
    chk("err_one_cycle", cif0.cfg_err, 1'b0);

    // Full straight load from a cleared counter.
    shift_cfg(mk_cfg(2'b01, 2'b01, 2'b01, 2'b01), CFG_W);
    chk("full_before_commit", {cif0.cfg_full, cif1.cfg_full}, 2'b11);
    step(1'b0, 1'b0, 1'b1);
    chk("str_s2", s2_0, 8'hA5);
    chk("str_err_low", cif0.cfg_err, 1'b0);
    chk("str_full_clr", cif0.cfg_full, 1'b0);
    n2m = 8'h5C; n4 = 16'h1234;
    step(1'b0, 1'b0, 1'b0);
    chk("str_s4", s4_0, 16'h1234);

    // Over-long load saturates and is rejected.
    shift_cfg(mk_cfg(2'b00, 2'b00, 2'b11, 2'b00), CFG_W + 1);
    chk("sat_not_full", cif0.cfg_full, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("sat_err", cif0.cfg_err, 1'b1);
    chk("sat_keep_str", s2_0, 8'h5C);

    // Hold on S2BEGb, committed together with a shift.
    n2e = 8'h0F;
    shift_cfg(mk_cfg(2'b00, 2'b00, 2'b11, 2'b00), CFG_W);
    step(1'b1, 1'b1, 1'b1);
    chk("hold_commit_ok", cif0.cfg_err, 1'b0);
    n2e = 8'hF0; n2m = 8'h81; n1 = 4'b0110;
    step(1'b0, 1'b0, 1'b0);
    chk("hold_s2b", s2b_0, 8'hF0);
    chk("hold_s2_track", s2_0, 8'h81);
    n2e = 8'h33;
    step(1'b0, 1'b0, 1'b0);
    chk("hold_s2b_p1", s2b_1, 8'hF0);
    shift_cfg(mk_cfg(2'b10, 2'b01, 2'b00, 2'b11), CFG_W - 1);
    chk("cnt_from_one_full", cif0.cfg_full, 1'b1);

    // Pipelined latency on S1BEG.
    n1 = 4'h1;
    step(1'b0, 1'b0, 1'b0);
    chk("pipe_s1_a", s1_1, 4'h8);
    n1 = 4'h2;
    step(1'b0, 1'b0, 1'b0);
    chk("pipe_s1_b", s1_1, 4'h4);

    // Reset in the middle of a load.
    shift_cfg(mk_cfg(2'b01, 2'b10, 2'b01, 2'b10), 20);
    mid_reset();
    step(1'b0, 1'b0, 1'b0);
    chk("post_rst_s1", s1_0, 4'h4);
    step(1'b0, 1'b0, 1'b0);
    chk("post_rst_p1_fold", s1_1, 4'h4);

    // Tie-low load after reset.
    n4 = 16'hBEEF; n2m = 8'hC3;
    shift_cfg(mk_cfg(2'b10, 2'b10, 2'b10, 2'b10), CFG_W);
    step(1'b0, 1'b0, 1'b1);
    chk("zero_all", {s4_0, s2b_0, s2_0, s1_0}, 36'h0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
